cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/arb_types.sv | 13 +
 rtl/arb_line_buf.sv | 26 ++
 rtl/cache_arbiter.sv | 138 +++++++++++++
 tb/tb_cache_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_types.sv
// Shared types for the icache/dcache to physical-memory arbiter.
package arb_types;

  localparam int unsigned LINE_WIDTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_line_buf.sv
// Line-wide capture register with load enable and asynchronous active-low clear.
module arb_line_buf
  import arb_types::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] d,
  output logic [LINE_WIDTH-1:0] q
);

  logic [LINE_WIDTH-1:0] line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= d;
    end
  end

  assign q = line_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache and dcache line traffic onto one physical memory port,
// preferring dcache but bounding how long icache can be starved.
module cache_arbiter
  import arb_types::*;
#(
  parameter int unsigned LINE_WIDTH   = LINE_WIDTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [31:0]           i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [31:0]           d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [31:0]           pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       starve_cnt_q, starve_cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  d_side_q, d_side_d;
  logic                  line_load;
  logic [LINE_WIDTH-1:0] line_data;
  logic                  i_req, d_req, i_forced;

  assign i_req    = i_pmem_read;
  assign d_req    = d_pmem_read | d_pmem_write;
  assign i_forced = i_req && (starve_cnt_q == StarveMax);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    write_d      = write_q;
    d_side_d     = d_side_q;
    line_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_d  = D_BUSY;
          addr_d   = d_pmem_address;
          wdata_d  = d_pmem_wdata;
          // Read and write together resolve to a write.
          write_d  = d_pmem_write;
          read_d   = ~d_pmem_write;
          d_side_d = 1'b1;
          if (i_req && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
        end else if (i_req) begin
          state_d      = I_BUSY;
          addr_d       = i_pmem_address;
          wdata_d      = '0;
          write_d      = 1'b0;
          read_d       = 1'b1;
          d_side_d     = 1'b0;
          starve_cnt_d = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          line_load = 1'b1;
          read_d    = 1'b0;
          write_d   = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      d_side_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      d_side_q     <= d_side_d;
    end
  end

  arb_line_buf #(
    .LINE_WIDTH(LINE_WIDTH)
  ) u_line_buf (
    .clk  (clk),
    .rst  (rst),
    .load (line_load),
    .d    (pmem_rdata),
    .q    (line_data)
  );

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = line_data;
  assign d_pmem_rdata = line_data;
  assign i_pmem_resp  = (state_q == RESP) && !d_side_q;
  assign d_pmem_resp  = (state_q == RESP) && d_side_q;

  always_ff @(posedge clk) begin
    if (rst && (state_q == IDLE)) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("cache_arbiter: d_pmem_read and d_pmem_write both high, handled as write");
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;
  import arb_types::*;

  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_pmem_read = 1'b0;
  logic [31:0]   i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [31:0]   d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(
    .LINE_WIDTH  (LW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ":pmem_read"}, pmem_read, 1'b0);
    chk({tag, ":pmem_write"}, pmem_write, 1'b0);
    chk({tag, ":i_resp"}, i_pmem_resp, 1'b0);
    chk({tag, ":d_resp"}, d_pmem_resp, 1'b0);
  endtask

  // Waits for a memory request, checks it, answers after lat cycles of assertion.
  task automatic mem_txn(input string tag, input int lat, input logic [LW-1:0] data,
                         input logic exp_d, input logic exp_wr, input logic [31:0] exp_addr,
                         input logic [LW-1:0] exp_wdata, input logic drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pmem_read || pmem_write) && n < 20);
    chk({tag, ":grant_seen"}, pmem_read || pmem_write, 1'b1);
    if (!(pmem_read || pmem_write)) return;
    chk({tag, ":write"}, pmem_write, exp_wr);
    chk({tag, ":read"}, pmem_read, !exp_wr);
    chk({tag, ":addr"}, pmem_address, exp_addr);
    if (exp_wr) chk({tag, ":wdata"}, pmem_wdata, exp_wdata);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      chk({tag, ":active"}, exp_wr ? pmem_write : pmem_read, 1'b1);
      chk({tag, ":overlap"}, pmem_read && pmem_write, 1'b0);
      chk({tag, ":early_resp"}, i_pmem_resp || d_pmem_resp, 1'b0);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = ~data;
    chk({tag, ":pmem_done"}, pmem_read || pmem_write, 1'b0);
    chk({tag, ":d_resp"}, d_pmem_resp, exp_d);
    chk({tag, ":i_resp"}, i_pmem_resp, !exp_d);
    chk({tag, ":rdata"}, exp_d ? d_pmem_rdata : i_pmem_rdata, data);
    if (drop) begin
      if (exp_d) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end else begin
        i_pmem_read = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, ":resp_one_cycle"}, i_pmem_resp || d_pmem_resp, 1'b0);
    chk({tag, ":rdata_held"}, i_pmem_rdata, data);
  endtask

  logic [LW-1:0] aa_line, wdata1, wdata2, last_line;

  initial begin
    aa_line = {32{8'hAA}};
    wdata1  = {8{32'hDEAD_BEEF}};
    wdata2  = {8{32'h1234_5678}};

    // Reset state
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset:rdata", i_pmem_rdata, '0);
    chk("reset:addr", pmem_address, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("idle");
    chk("idle:state", dut.state_q, IDLE);

    // Icache fill, 5-cycle memory latency
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0040;
    mem_txn("icache_rd", 5, aa_line, 1'b0, 1'b0, 32'h0000_0040, '0, 1'b1);

    // Simultaneous requests: dcache write wins, then icache
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0080;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_1000;
    d_pmem_wdata   = wdata1;
    mem_txn("both_d", 3, {8{32'h0BAD_F00D}}, 1'b1, 1'b1, 32'h0000_1000, wdata1, 1'b1);
    mem_txn("both_i", 2, {8{32'hCAFE_0001}}, 1'b0, 1'b0, 32'h0000_0080, '0, 1'b1);
    chk("both:starve_clear", dut.starve_cnt_q, 0);

    // Starvation bound: icache held while dcache reads back to back
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0040;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_2000;
    for (int g = 0; g < 4; g++) begin
      mem_txn("starve_d", 2, {8{32'h2000_0000 + g}}, 1'b1, 1'b0, 32'h0000_2000, '0, 1'b0);
    end
    chk("starve:cnt_sat", dut.starve_cnt_q, 4);
    mem_txn("starve_i", 2, {8{32'h1111_1111}}, 1'b0, 1'b0, 32'h0000_0040, '0, 1'b1);
    chk("starve:cnt_clear", dut.starve_cnt_q, 0);
    mem_txn("starve_d5", 2, {8{32'h2000_0005}}, 1'b1, 1'b0, 32'h0000_2000, '0, 1'b0);
    mem_txn("starve_d6", 2, {8{32'h2000_0006}}, 1'b1, 1'b0, 32'h0000_2000, '0, 1'b1);
    chk("starve:cnt_end", dut.starve_cnt_q, 0);

    // Reset in the middle of a dcache transaction
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_3000;
    @(negedge clk);
    chk("rst_mid:busy", pmem_read, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid:rdata", d_pmem_rdata, '0);
    chk("rst_mid:addr", pmem_address, 32'h0);
    chk("rst_mid:state", dut.state_q, IDLE);
    d_pmem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_quiet("rst_after");
    end
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_3040;
    mem_txn("post_rst", 3, {8{32'h3333_3333}}, 1'b1, 1'b0, 32'h0000_3040, '0, 1'b1);

    // Read and write together: handled as a write
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_4000;
    d_pmem_wdata   = wdata2;
    last_line      = {8{32'h4444_4444}};
    mem_txn("rw_both", 2, last_line, 1'b1, 1'b1, 32'h0000_4000, wdata2, 1'b1);

    // Stray memory response while idle
    pmem_resp  = 1'b1;
    pmem_rdata = {32{8'h55}};
    @(negedge clk);
    pmem_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk_quiet("stray");
      chk("stray:state", dut.state_q, IDLE);
      chk("stray:rdata", i_pmem_rdata, last_line);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
